// File: rtl/battleship_pkg.sv
// Shared types for the parametrised Battleship core.
//  cell_t       : contents of one board cell
//  game_state_t : top-level game phase, exported on state_o
//  LFSR_TAPS    : feedback mask for x^8+x^6+x^5+x^4+1 (bits 7,5,4,3)
package battleship_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        SHIP  = 2'd1,
        HIT   = 2'd2,
        MISS  = 2'd3
    } cell_t;

    typedef enum logic [2:0] {
        DECIDE      = 3'd0,
        PLACE       = 3'd1,
        PC_PLACE    = 3'd2,
        PLAYER_TURN = 3'd3,
        PC_TURN     = 3'd4,
        WIN         = 3'd5,
        LOSE        = 3'd6
    } game_state_t;

    localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/battleship_core_param_if.sv
// Player-facing bus of the Battleship core.
//  master : buttons, requested ship count, board read address (driven by the UI side)
//  slave  : the core; returns read data, cursor, game state, counters and flags
interface battleship_if
    import battleship_pkg::*;
#(
    parameter int unsigned BOARD_N   = 5,
    parameter int unsigned MAX_SHIPS = 5
);
    localparam int unsigned IDX_W = $clog2(BOARD_N);
    localparam int unsigned CNT_W = $clog2(MAX_SHIPS + 1);

    logic             btn_up;
    logic             btn_down;
    logic             btn_left;
    logic             btn_right;
    logic             btn_confirm;
    logic [CNT_W-1:0] ship_count_in;
    logic             rd_board;
    logic [IDX_W-1:0] rd_i;
    logic [IDX_W-1:0] rd_j;
    cell_t            rd_cell;
    logic [IDX_W-1:0] cursor_i;
    logic [IDX_W-1:0] cursor_j;
    game_state_t      state_o;
    logic [CNT_W-1:0] ships_to_place;
    logic [CNT_W-1:0] player_left;
    logic [CNT_W-1:0] pc_left;
    logic             placement_error;
    logic             player_won;

    modport master (
        output btn_up, btn_down, btn_left, btn_right, btn_confirm,
        output ship_count_in, rd_board, rd_i, rd_j,
        input  rd_cell, cursor_i, cursor_j, state_o,
        input  ships_to_place, player_left, pc_left, placement_error, player_won
    );

    modport slave (
        input  btn_up, btn_down, btn_left, btn_right, btn_confirm,
        input  ship_count_in, rd_board, rd_i, rd_j,
        output rd_cell, cursor_i, cursor_j, state_o,
        output ships_to_place, player_left, pc_left, placement_error, player_won
    );

endinterface

// File: rtl/battleship_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR used to pick the PC's scan start cell.
//  clk, rst (sync, active-low) ; q : current LFSR value (SEED after reset, must be non-zero)
module battleship_lfsr8
    import battleship_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] q
);

    // Shift left, new LSB is the parity of the tapped bits.
    always_ff @(posedge clk) begin
        if (!rst) q <= SEED;
        else      q <= {q[6:0], ^(q & LFSR_TAPS)};
    end

endmodule

// File: rtl/battleship_core_param.sv
// Battleship game core on a BOARD_N x BOARD_N board: ship count, cursor, player and PC
// placement, alternating shots, win/lose detection, registered board read port.
//  clk, rst (sync, active-low) ; bus : battleship_if slave (buttons, read port, status)
module battleship_core_param
    import battleship_pkg::*;
#(
    parameter int unsigned BOARD_N   = 5,
    parameter int unsigned MAX_SHIPS = 5,
    parameter logic [7:0]  LFSR_SEED = 8'hA5,
    parameter int unsigned PC_DELAY  = 16
) (
    input logic         clk,
    input logic         rst,
    battleship_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(BOARD_N);
    localparam int unsigned CNT_W = $clog2(MAX_SHIPS + 1);
    localparam int unsigned CELLS = BOARD_N * BOARD_N;
    localparam int unsigned PTR_W = $clog2(CELLS);
    localparam int unsigned DLY_W = $clog2(PC_DELAY + 1);

    game_state_t      state, state_n;
    cell_t            player_b [CELLS];
    cell_t            pc_b     [CELLS];
    logic [4:0]       btn_now, btn_q, btn_ev;
    logic [IDX_W-1:0] cur_i, cur_j;
    logic [CNT_W-1:0] to_place, p_left, c_left, pc_placed, n_req;
    logic [PTR_W-1:0] ptr, ptr_next, ptr_seed, cur_idx, rd_idx;
    logic [DLY_W-1:0] dly;
    logic [7:0]       lfsr;
    logic             err, won, confirm, rd_in_range;
    cell_t            rd_q, rd_value;
    logic             latch_n, place_wr, place_err, pc_wr, scan_adv;
    logic             shot_ok, shot_err, pc_shot, dly_inc, clear_all, move_en;

    battleship_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (.clk(clk), .rst(rst), .q(lfsr));

    // Button order: {confirm, right, left, down, up}; rising edge = one event.
    assign btn_now  = {bus.btn_confirm, bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};
    assign btn_ev   = btn_now & ~btn_q;
    assign confirm  = btn_ev[4];
    assign cur_idx  = PTR_W'(32'(cur_i) * BOARD_N + 32'(cur_j));
    assign ptr_seed = PTR_W'(32'(lfsr) % CELLS);
    assign ptr_next = (ptr == PTR_W'(CELLS - 1)) ? '0 : ptr + PTR_W'(1);

    // Requested ship count clamped to 1..MAX_SHIPS.
    always_comb begin
        n_req = bus.ship_count_in;
        if (bus.ship_count_in == '0)                      n_req = CNT_W'(1);
        else if (bus.ship_count_in > CNT_W'(MAX_SHIPS))   n_req = CNT_W'(MAX_SHIPS);
    end

    // Read port mux; off-board coordinates read as EMPTY.
    always_comb begin
        rd_in_range = (32'(bus.rd_i) < BOARD_N) && (32'(bus.rd_j) < BOARD_N);
        rd_idx      = rd_in_range ? PTR_W'(32'(bus.rd_i) * BOARD_N + 32'(bus.rd_j)) : '0;
        rd_value    = EMPTY;
        if (rd_in_range) rd_value = bus.rd_board ? pc_b[rd_idx] : player_b[rd_idx];
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= DECIDE;
        else      state <= state_n;
    end

    // Next state plus one-hot datapath strobes.
    always_comb begin
        state_n   = state;
        latch_n   = 1'b0;
        place_wr  = 1'b0;
        place_err = 1'b0;
        pc_wr     = 1'b0;
        scan_adv  = 1'b0;
        shot_ok   = 1'b0;
        shot_err  = 1'b0;
        pc_shot   = 1'b0;
        dly_inc   = 1'b0;
        clear_all = 1'b0;
        move_en   = 1'b0;
        case (state)
            DECIDE: begin
                if (confirm) begin
                    latch_n = 1'b1;
                    state_n = PLACE;
                end
            end
            PLACE: begin
                move_en = ~confirm;
                if (confirm) begin
                    if (player_b[cur_idx] == EMPTY) begin
                        place_wr = 1'b1;
                        if (to_place == CNT_W'(1)) state_n = PC_PLACE;
                    end else begin
                        place_err = 1'b1;
                    end
                end
            end
            PC_PLACE: begin
                if (pc_b[ptr] == EMPTY) begin
                    pc_wr = 1'b1;
                    if (pc_placed + CNT_W'(1) == c_left) state_n = PLAYER_TURN;
                end else begin
                    scan_adv = 1'b1;
                end
            end
            PLAYER_TURN: begin
                move_en = ~confirm;
                if (confirm) begin
                    case (pc_b[cur_idx])
                        EMPTY:   begin shot_ok = 1'b1; state_n = PC_TURN; end
                        SHIP:    begin
                            shot_ok = 1'b1;
                            state_n = (c_left == CNT_W'(1)) ? WIN : PC_TURN;
                        end
                        default: shot_err = 1'b1;
                    endcase
                end
            end
            PC_TURN: begin
                if (dly != DLY_W'(PC_DELAY)) begin
                    dly_inc = 1'b1;
                end else if (player_b[ptr] == EMPTY || player_b[ptr] == SHIP) begin
                    pc_shot = 1'b1;
                    if (player_b[ptr] == SHIP && p_left == CNT_W'(1)) state_n = LOSE;
                    else                                               state_n = PLAYER_TURN;
                end else begin
                    scan_adv = 1'b1;
                end
            end
            WIN, LOSE: begin
                if (confirm) begin
                    clear_all = 1'b1;
                    state_n   = DECIDE;
                end
            end
            default: state_n = DECIDE;
        endcase
    end

    // Datapath: boards, counters, cursor, scan pointer, read register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            btn_q     <= btn_now;
            cur_i     <= '0;
            cur_j     <= '0;
            to_place  <= '0;
            p_left    <= '0;
            c_left    <= '0;
            pc_placed <= '0;
            ptr       <= '0;
            dly       <= '0;
            err       <= 1'b0;
            won       <= 1'b0;
            rd_q      <= EMPTY;
            for (int k = 0; k < int'(CELLS); k++) begin
                player_b[k] <= EMPTY;
                pc_b[k]     <= EMPTY;
            end
        end else begin
            btn_q <= btn_now;
            won   <= (state_n == WIN);
            rd_q  <= rd_value;
            if (latch_n) begin
                to_place <= n_req;
                p_left   <= n_req;
                c_left   <= n_req;
            end
            if (place_wr) begin
                player_b[cur_idx] <= SHIP;
                to_place          <= to_place - CNT_W'(1);
                err               <= 1'b0;
            end
            if (place_err || shot_err) err <= 1'b1;
            if (state == PLACE && state_n == PC_PLACE) begin
                ptr       <= ptr_seed;
                pc_placed <= '0;
            end
            if (pc_wr) begin
                pc_b[ptr] <= SHIP;
                pc_placed <= pc_placed + CNT_W'(1);
                ptr       <= ptr_next;
            end
            if (scan_adv) ptr <= ptr_next;
            if (shot_ok) begin
                err <= 1'b0;
                if (pc_b[cur_idx] == SHIP) begin
                    pc_b[cur_idx] <= HIT;
                    if (c_left != '0) c_left <= c_left - CNT_W'(1);
                end else begin
                    pc_b[cur_idx] <= MISS;
                end
                // Fresh random start for the PC's next search.
                ptr <= ptr_seed;
                dly <= '0;
            end
            if (dly_inc) dly <= dly + DLY_W'(1);
            if (pc_shot) begin
                if (player_b[ptr] == SHIP) begin
                    player_b[ptr] <= HIT;
                    if (p_left != '0) p_left <= p_left - CNT_W'(1);
                end else begin
                    player_b[ptr] <= MISS;
                end
            end
            // Cursor wraps on every edge; priority up > down > left > right.
            if (move_en) begin
                if (btn_ev[0])      cur_i <= (cur_i == '0) ? IDX_W'(BOARD_N - 1) : cur_i - IDX_W'(1);
                else if (btn_ev[1]) cur_i <= (cur_i == IDX_W'(BOARD_N - 1)) ? '0 : cur_i + IDX_W'(1);
                else if (btn_ev[2]) cur_j <= (cur_j == '0) ? IDX_W'(BOARD_N - 1) : cur_j - IDX_W'(1);
                else if (btn_ev[3]) cur_j <= (cur_j == IDX_W'(BOARD_N - 1)) ? '0 : cur_j + IDX_W'(1);
            end
            if (clear_all) begin
                cur_i    <= '0;
                cur_j    <= '0;
                to_place <= '0;
                p_left   <= '0;
                c_left   <= '0;
                err      <= 1'b0;
                for (int k = 0; k < int'(CELLS); k++) begin
                    player_b[k] <= EMPTY;
                    pc_b[k]     <= EMPTY;
                end
            end
        end
    end

    assign bus.rd_cell         = rd_q;
    assign bus.cursor_i        = cur_i;
    assign bus.cursor_j        = cur_j;
    assign bus.state_o         = state;
    assign bus.ships_to_place  = to_place;
    assign bus.player_left     = p_left;
    assign bus.pc_left         = c_left;
    assign bus.placement_error = err;
    assign bus.player_won      = won;

endmodule

// File: tb/tb_battleship_core_param.sv
// Scoreboard bench for battleship_core_param: stimulus pushes expected status / read data
// into queues, a negedge monitor pops and compares. PC choices are random in the DUT, so
// they are learned by snapshotting a board and checked against the game rules.
module tb_battleship_core_param;
    import battleship_pkg::*;

    localparam int N     = 5;
    localparam int MS    = 5;
    localparam int DLY   = 16;
    localparam int CELLS = N * N;
    localparam int IW    = $clog2(N);
    localparam int CW    = $clog2(MS + 1);

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    battleship_if #(.BOARD_N(N), .MAX_SHIPS(MS)) bus ();

    battleship_core_param #(
        .BOARD_N(N), .MAX_SHIPS(MS), .LFSR_SEED(8'hA5), .PC_DELAY(DLY)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    typedef struct { string nm; int board; int i; int j; cell_t exp; bit snap; } rd_exp_t;
    typedef struct { string nm; game_state_t st; int ci; int cj; int stp; int pl; int pcl; int err; int won; } st_exp_t;

    rd_exp_t rd_q[$];
    st_exp_t st_q[$];
    logic    rd_req = 1'b0;
    logic    rd_vld = 1'b0;
    cell_t   snap_pl [CELLS];
    cell_t   snap_pc [CELLS];

    int total = 0;
    int bad   = 0;

    // Reference model of the game at rule level.
    game_state_t m_st;
    int          m_ci, m_cj, m_stp, m_pl, m_pcl, m_err;
    cell_t       m_ply [CELLS];
    cell_t       m_pc  [CELLS];

    localparam logic [4:0] B_UP = 5'b00001, B_DN = 5'b00010, B_LF = 5'b00100, B_RT = 5'b01000, B_CF = 5'b10000;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(posedge clk) rd_vld <= rd_req;

    // Monitor: read data one cycle after each request, status whenever queued.
    always @(negedge clk) begin : mon
        rd_exp_t e;
        st_exp_t s;
        if (rd_vld) begin
            if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
            else begin
                e = rd_q.pop_front();
                if (e.snap) begin
                    if (e.board == 0) snap_pl[e.i * N + e.j] = bus.rd_cell;
                    else              snap_pc[e.i * N + e.j] = bus.rd_cell;
                end else begin
                    chk(e.nm, int'(bus.rd_cell), int'(e.exp));
                end
            end
        end
        while (st_q.size() > 0) begin
            s = st_q.pop_front();
            chk({s.nm, ".state"},  int'(bus.state_o),         int'(s.st));
            chk({s.nm, ".cur_i"},  int'(bus.cursor_i),        s.ci);
            chk({s.nm, ".cur_j"},  int'(bus.cursor_j),        s.cj);
            chk({s.nm, ".to_pl"},  int'(bus.ships_to_place),  s.stp);
            chk({s.nm, ".pl_lf"},  int'(bus.player_left),     s.pl);
            chk({s.nm, ".pc_lf"},  int'(bus.pc_left),         s.pcl);
            chk({s.nm, ".err"},    int'(bus.placement_error), s.err);
            chk({s.nm, ".won"},    int'(bus.player_won),      s.won);
        end
    end

    task automatic model_reset();
        m_st = DECIDE; m_ci = 0; m_cj = 0; m_stp = 0; m_pl = 0; m_pcl = 0; m_err = 0;
        for (int k = 0; k < CELLS; k++) begin m_ply[k] = EMPTY; m_pc[k] = EMPTY; end
    endtask

    task automatic model_press(input logic [4:0] m);
        int n, idx;
        idx = m_ci * N + m_cj;
        if (m[4]) begin
            case (m_st)
                DECIDE: begin
                    n = int'(bus.ship_count_in);
                    if (n < 1) n = 1;
                    if (n > MS) n = MS;
                    m_stp = n; m_pl = n; m_pcl = n; m_st = PLACE;
                end
                PLACE: begin
                    if (m_ply[idx] == EMPTY) begin
                        m_ply[idx] = SHIP; m_stp--; m_err = 0;
                        if (m_stp == 0) m_st = PC_PLACE;
                    end else m_err = 1;
                end
                PLAYER_TURN: begin
                    if (m_pc[idx] == EMPTY) begin
                        m_pc[idx] = MISS; m_err = 0; m_st = PC_TURN;
                    end else if (m_pc[idx] == SHIP) begin
                        m_pc[idx] = HIT; m_pcl--; m_err = 0;
                        m_st = (m_pcl == 0) ? WIN : PC_TURN;
                    end else m_err = 1;
                end
                WIN, LOSE: begin
                    model_reset();
                end
                default: ;
            endcase
        end else if (m_st == PLACE || m_st == PLAYER_TURN) begin
            if (m[0])      m_ci = (m_ci == 0) ? N - 1 : m_ci - 1;
            else if (m[1]) m_ci = (m_ci == N - 1) ? 0 : m_ci + 1;
            else if (m[2]) m_cj = (m_cj == 0) ? N - 1 : m_cj - 1;
            else if (m[3]) m_cj = (m_cj == N - 1) ? 0 : m_cj + 1;
        end
    endtask

    task automatic st_check(input string nm);
        st_exp_t s;
        s.nm = nm; s.st = m_st; s.ci = m_ci; s.cj = m_cj; s.stp = m_stp;
        s.pl = m_pl; s.pcl = m_pcl; s.err = m_err; s.won = (m_st == WIN) ? 1 : 0;
        st_q.push_back(s);
    endtask

    task automatic set_btns(input logic [4:0] m);
        bus.btn_up = m[0]; bus.btn_down = m[1]; bus.btn_left = m[2];
        bus.btn_right = m[3]; bus.btn_confirm = m[4];
    endtask

    task automatic press(input logic [4:0] m);
        model_press(m);
        set_btns(m);
        @(posedge clk); #1;
        set_btns(5'b0);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
    endtask

    task automatic read_cell(input int b, input int i, input int j, input cell_t exp, input bit snap, input string nm);
        rd_exp_t e;
        bus.rd_board = b[0]; bus.rd_i = IW'(i); bus.rd_j = IW'(j);
        e.nm = nm; e.board = b; e.i = i; e.j = j; e.exp = exp; e.snap = snap;
        rd_q.push_back(e);
        rd_req = 1'b1;
        @(posedge clk); #1;
        rd_req = 1'b0;
    endtask

    task automatic snap_board(input int b);
        for (int k = 0; k < CELLS; k++) read_cell(b, k / N, k % N, EMPTY, 1'b1, "snap");
        @(posedge clk); #1;
    endtask

    task automatic check_board(input int b, input string nm);
        for (int k = 0; k < CELLS; k++)
            read_cell(b, k / N, k % N, (b == 0) ? m_ply[k] : m_pc[k], 1'b0, $sformatf("%s[%0d]", nm, k));
        @(posedge clk); #1;
    endtask

    task automatic wait_leave(input game_state_t st, input int budget, input string nm, output int cyc);
        cyc = 0;
        while (bus.state_o == st && cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (bus.state_o == st) chk({nm, ".timeout"}, 1, 0);
    endtask

    task automatic goto(input int i, input int j);
        while (m_ci != i) press(B_DN);
        while (m_cj != j) press(B_RT);
    endtask

    // PC placement: ship count and cell kinds follow the rules; board then adopted by the model.
    task automatic pc_place_check(input string nm);
        int cyc, ships, other;
        wait_leave(PC_PLACE, 2 * CELLS, nm, cyc);
        snap_board(1);
        ships = 0; other = 0;
        for (int k = 0; k < CELLS; k++) begin
            if (snap_pc[k] == SHIP) ships++;
            else if (snap_pc[k] != EMPTY) other++;
            m_pc[k] = snap_pc[k];
        end
        chk({nm, ".pc_ships"}, ships, m_pcl);
        chk({nm, ".pc_other"}, other, 0);
        m_st = PLAYER_TURN;
        st_check({nm, ".after"});
    endtask

    // PC shot: waits out the delay, then exactly one legal change on the player board.
    task automatic pc_turn_check(input string nm);
        int cyc, diffs, legal, hit;
        wait_leave(PC_TURN, DLY + CELLS + 4, nm, cyc);
        chk({nm, ".pc_delay_ok"}, (cyc + 1 >= DLY) ? 1 : 0, 1);
        snap_board(0);
        diffs = 0; legal = 1; hit = 0;
        for (int k = 0; k < CELLS; k++) begin
            if (snap_pl[k] != m_ply[k]) begin
                diffs++;
                if (m_ply[k] == SHIP && snap_pl[k] == HIT) hit = 1;
                else if (!(m_ply[k] == EMPTY && snap_pl[k] == MISS)) legal = 0;
                m_ply[k] = snap_pl[k];
            end
        end
        chk({nm, ".pc_changes"}, diffs, 1);
        chk({nm, ".pc_legal"}, legal, 1);
        if (hit == 1 && m_pl > 0) m_pl--;
        m_st = (m_pl == 0) ? LOSE : PLAYER_TURN;
        st_check({nm, ".after_pc"});
    endtask

    task automatic place(input int idx, input string nm);
        goto(idx / N, idx % N);
        press(B_CF);
        if (m_st == PC_PLACE) pc_place_check(nm);
        else st_check(nm);
    endtask

    task automatic shoot(input int idx, input string nm);
        goto(idx / N, idx % N);
        press(B_CF);
        st_check(nm);
        if (m_st == PC_TURN) pc_turn_check(nm);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard, idx, s;
        set_btns(5'b0);
        bus.ship_count_in = '0; bus.rd_board = 1'b0; bus.rd_i = '0; bus.rd_j = '0;
        repeat (2) @(posedge clk);
        #1; rst = 1'b1;
        model_reset();
        st_check("reset");
        read_cell(0, 0, 0, EMPTY, 1'b0, "rst_pl00");
        read_cell(1, 4, 4, EMPTY, 1'b0, "rst_pc44");
        read_cell(1, 5, 2, EMPTY, 1'b0, "oob_row");

        // Confirm held through reset must not count as an edge.
        bus.btn_confirm = 1'b1; rst = 1'b0;
        @(posedge clk); #1; rst = 1'b1;
        repeat (2) @(posedge clk);
        #1; st_check("held_confirm");
        bus.btn_confirm = 1'b0;
        @(posedge clk); #1;

        // Ship count clamping.
        bus.ship_count_in = CW'(0); press(B_CF); st_check("cnt0");
        do_reset();
        bus.ship_count_in = CW'(7); press(B_CF); st_check("cnt7");

        // Cursor wrap and priority.
        press(B_UP); st_check("cur_up");
        press(B_LF); st_check("cur_upleft");
        press(B_DN); press(B_RT); st_check("cur_home");
        press(B_UP | B_RT); st_check("cur_up_right");
        for (int k = 0; k < 16; k++) begin
            press(5'($urandom_range(1, 15)));
            st_check($sformatf("cur_rnd%0d", k));
        end
        press(B_CF | B_UP); st_check("conf_beats_move");

        // Placement with duplicate, then PC placement.
        do_reset();
        bus.ship_count_in = CW'(2); press(B_CF); st_check("n2");
        place(1 * N + 1, "place11");
        press(B_CF); st_check("dup_place");
        place(2 * N + 3, "place23");
        check_board(0, "pl_board");

        // Hit a PC ship, repeat the shot, then sink the last one.
        idx = -1;
        for (int k = 0; k < CELLS; k++) if (idx < 0 && m_pc[k] == SHIP) idx = k;
        if (idx < 0) idx = 0;
        shoot(idx, "shot1");
        press(B_CF); st_check("dup_shot");
        repeat (DLY + 4) @(posedge clk);
        #1; st_check("no_pc_move");
        check_board(0, "pl_after_dup");
        guard = 0;
        while (m_st == PLAYER_TURN && guard < 40) begin
            idx = -1;
            for (int k = 0; k < CELLS; k++) if (idx < 0 && m_pc[k] == SHIP) idx = k;
            if (idx < 0) break;
            shoot(idx, "sink");
            guard++;
        end
        chk("win_reached", int'(m_st), int'(WIN));
        st_check("win");
        check_board(1, "pc_win");
        press(B_CF); st_check("restart");
        check_board(0, "pl_clear");
        check_board(1, "pc_clear");

        // Reset while the PC is placing.
        bus.ship_count_in = CW'(5); press(B_CF);
        for (int k = 0; k < 4; k++) place(k, $sformatf("p5_%0d", k));
        goto(0, 4);
        bus.btn_confirm = 1'b1;
        @(posedge clk); #1;
        bus.btn_confirm = 1'b0; rst = 1'b0;
        chk("in_pc_place", int'(bus.state_o), int'(PC_PLACE));
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
        st_check("rst_mid");
        check_board(0, "pl_rst");
        check_board(1, "pc_rst");

        // Random games against the rule model.
        for (int g = 0; g < 2; g++) begin
            bus.ship_count_in = CW'($urandom_range(0, 7));
            press(B_CF); st_check($sformatf("g%0d_decide", g));
            guard = 0;
            while (m_st == PLACE && guard < 60) begin
                place(int'($urandom_range(0, CELLS - 1)), $sformatf("g%0d_pl%0d", g, guard));
                guard++;
            end
            guard = 0;
            while (m_st == PLAYER_TURN && guard < 150) begin
                idx = int'($urandom_range(0, CELLS - 1));
                if ($urandom_range(0, 99) < 85) begin
                    s = idx;
                    for (int k = 0; k < CELLS; k++) begin
                        if (m_pc[(s + k) % CELLS] == EMPTY || m_pc[(s + k) % CELLS] == SHIP) begin
                            idx = (s + k) % CELLS;
                            break;
                        end
                    end
                end
                shoot(idx, $sformatf("g%0d_s%0d", g, guard));
                guard++;
            end
            st_check($sformatf("g%0d_end", g));
            press(B_CF); st_check($sformatf("g%0d_restart", g));
        end

        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
